// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI transmitter: FSM states, frame size and
// the default command byte (write-and-update).
package dac_spi_pkg;

  localparam int FRAME_BITS = 24;
  localparam logic [7:0] DEFAULT_DAC_CMD = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

endpackage

// File: rtl/dac_spi_tx_tick_gen.sv
// Modulo-N sample counter. Counts 0..N-1 while enabled and pulses tick for
// the one clock where the count sits at N-1; held at zero while disabled, so
// the first tick after enable rises lands N clocks later.
module tick_gen #(
  parameter int unsigned N = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(N - 1);

  logic [15:0] count_q, count_d;

  // Next count: clear when disabled, wrap at the last value.
  always_comb begin
    count_d = count_q;
    if (!en) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI frame transmitter for the DAC: on each sample tick sends the 24-bit
// frame {DAC_CMD, data_in} MSB first, framed by cs_n, with mosi changing on
// the falling sclk edge so the DAC samples on the rising one.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter logic [7:0]  DAC_CMD       = DEFAULT_DAC_CMD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] data_in,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output state_t      state_dbg
);

  localparam logic [7:0] HP_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);

  logic tick;

  state_t                  state_q, state_d;
  logic [7:0]              hp_cnt_q, hp_cnt_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    cs_n_q, cs_n_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overrun_q, overrun_d;
  logic                    hp_last;
  logic                    can_start;

  tick_gen #(
    .N(SAMPLE_PERIOD)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (enable),
    .tick(tick)
  );

  // Next-state and output logic. The final GAP clock is the IDLE re-entry
  // edge, so a tick arriving there starts the next frame directly; this lets
  // SAMPLE_PERIOD = 51*CLK_DIV stream frames back-to-back without overrun.
  always_comb begin
    state_d      = state_q;
    hp_cnt_d     = hp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;
    frame_done_d = 1'b0;

    hp_last   = (hp_cnt_q == HP_LAST);
    can_start = (state_q == ST_IDLE) || ((state_q == ST_GAP) && hp_last);

    if (state_q != ST_IDLE) begin
      hp_cnt_d = hp_last ? 8'd0 : hp_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        hp_cnt_d = '0;
      end
      ST_CS_SETUP: begin
        if (hp_last) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (hp_last) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_CS_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
              mosi_d    = shift_q[FRAME_BITS-2];
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (hp_last) begin
          cs_n_d       = 1'b1;
          frame_done_d = 1'b1;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (hp_last) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tick && can_start) begin
      state_d   = ST_CS_SETUP;
      shift_d   = {DAC_CMD, data_in};
      mosi_d    = DAC_CMD[7];
      cs_n_d    = 1'b0;
      sclk_d    = 1'b0;
      hp_cnt_d  = '0;
      bit_cnt_d = '0;
    end

    if (!enable) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q | (tick & ~can_start);
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hp_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_cnt_q     <= hp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (A: div 2 / period 120, B: div 2 /
// period 60, C: div 1 / period 51) checked every cycle against a frame-offset
// model, with a frame scoreboard and directed literal expectations.
module tb_dac_spi_tx;
  import dac_spi_pkg::*;

  localparam logic [7:0] CMD = 8'h30;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  en_v  = 3'b000;
  logic [15:0] din [3];
  logic [2:0]  sclk_v, mosi_v, cs_n_v, busy_v, done_v, ovr_v;
  state_t      st_v [3];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  dac_spi_tx #(.CLK_DIV(2), .SAMPLE_PERIOD(120)) u_a (
    .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .data_in(din[0]),
    .sclk(sclk_v[0]), .mosi(mosi_v[0]), .cs_n(cs_n_v[0]), .busy(busy_v[0]),
    .frame_done(done_v[0]), .overrun(ovr_v[0]), .state_dbg(st_v[0]));

  dac_spi_tx #(.CLK_DIV(2), .SAMPLE_PERIOD(60)) u_b (
    .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .data_in(din[1]),
    .sclk(sclk_v[1]), .mosi(mosi_v[1]), .cs_n(cs_n_v[1]), .busy(busy_v[1]),
    .frame_done(done_v[1]), .overrun(ovr_v[1]), .state_dbg(st_v[1]));

  dac_spi_tx #(.CLK_DIV(1), .SAMPLE_PERIOD(51)) u_c (
    .clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .data_in(din[2]),
    .sclk(sclk_v[2]), .mosi(mosi_v[2]), .cs_n(cs_n_v[2]), .busy(busy_v[2]),
    .frame_done(done_v[2]), .overrun(ovr_v[2]), .state_dbg(st_v[2]));

  function automatic int div_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int per_of(input int i);
    return (i == 0) ? 120 : ((i == 1) ? 60 : 51);
  endfunction

  function automatic string inst_name(input int i);
    return (i == 0) ? "a" : ((i == 1) ? "b" : "c");
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cycle);
  endtask

  // scoreboard: expected frames per instance
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  logic [23:0] exp_q2[$];

  task automatic q_push(input int i, input logic [23:0] v);
    case (i)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic q_clear(input int i);
    case (i)
      0: exp_q0.delete();
      1: exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  task automatic q_pop(input int i, output logic ok, output logic [23:0] v);
    ok = 1'b0;
    v  = '0;
    case (i)
      0: if (exp_q0.size() > 0) begin ok = 1'b1; v = exp_q0.pop_front(); end
      1: if (exp_q1.size() > 0) begin ok = 1'b1; v = exp_q1.pop_front(); end
      default: if (exp_q2.size() > 0) begin ok = 1'b1; v = exp_q2.pop_front(); end
    endcase
  endtask

  // model: m_k is clocks since the frame's start edge (-1 when idle)
  int          m_cnt [3] = '{0, 0, 0};
  int          m_k   [3] = '{-1, -1, -1};
  logic [23:0] m_frame [3] = '{24'h0, 24'h0, 24'h0};
  logic        m_ovr [3] = '{1'b0, 1'b0, 1'b0};

  task automatic model_step(input int i);
    int   len;
    logic tick, free;
    len = 51 * div_of(i);
    if (rst_v[i]) begin
      m_cnt[i] = 0;
      m_k[i]   = -1;
      m_ovr[i] = 1'b0;
      q_clear(i);
    end else begin
      tick = en_v[i] && (m_cnt[i] == per_of(i) - 1);
      free = (m_k[i] < 0) || (m_k[i] == len - 1);
      if (!en_v[i] || tick) m_cnt[i] = 0;
      else m_cnt[i] = m_cnt[i] + 1;
      if (m_k[i] >= 0) m_k[i] = (m_k[i] == len - 1) ? -1 : m_k[i] + 1;
      if (tick && free) begin
        m_k[i]     = 0;
        m_frame[i] = {CMD, din[i]};
        q_push(i, m_frame[i]);
      end
      if (!en_v[i]) m_ovr[i] = 1'b0;
      else if (tick && !free) m_ovr[i] = 1'b1;
    end
  endtask

  task automatic compare(input int i);
    int    d, k, j, b;
    logic  e_busy, e_cs_n, e_done, e_sclk;
    string n;
    d = div_of(i);
    k = m_k[i];
    n = inst_name(i);
    e_busy = (k >= 0);
    e_cs_n = !((k >= 0) && (k < 50 * d));
    e_done = (k == 50 * d);
    e_sclk = 1'b0;
    if ((k >= d) && (k < 49 * d)) begin
      j = k - d;
      e_sclk = ((j % (2 * d)) >= d);
    end
    check({n, "_busy"}, busy_v[i], e_busy);
    check({n, "_cs_n"}, cs_n_v[i], e_cs_n);
    check({n, "_frame_done"}, done_v[i], e_done);
    check({n, "_sclk"}, sclk_v[i], e_sclk);
    check({n, "_overrun"}, ovr_v[i], m_ovr[i]);
    if ((k >= 0) && (k < 49 * d)) begin
      b = (k < d) ? 0 : (k - d) / (2 * d);
      check({n, "_mosi"}, mosi_v[i], m_frame[i][23 - b]);
    end
  endtask

  // observation of DUT outputs for scoreboard and literal checks
  logic        prev_sclk [3] = '{1'b0, 1'b0, 1'b0};
  logic [23:0] cap_word  [3] = '{24'h0, 24'h0, 24'h0};
  logic [23:0] last_word [3] = '{24'h0, 24'h0, 24'h0};
  int cap_bits [3]      = '{0, 0, 0};
  int last_bits [3]     = '{0, 0, 0};
  int done_cnt [3]      = '{0, 0, 0};
  int last_done_cyc [3] = '{0, 0, 0};
  int done_iv [3]       = '{0, 0, 0};
  int low_run [3]       = '{0, 0, 0};
  int high_run [3]      = '{0, 0, 0};
  int last_low [3]      = '{0, 0, 0};
  int last_high [3]     = '{0, 0, 0};

  task automatic monitor(input int i);
    logic        ok;
    logic [23:0] exp_w;
    string       n;
    n = inst_name(i);
    if (sclk_v[i] && !prev_sclk[i] && !cs_n_v[i]) begin
      cap_word[i] = {cap_word[i][22:0], mosi_v[i]};
      cap_bits[i]++;
    end
    prev_sclk[i] = sclk_v[i];
    if (done_v[i]) begin
      q_pop(i, ok, exp_w);
      check({n, "_sb_frame_expected"}, ok, 1'b1);
      if (ok) check({n, "_sb_word"}, cap_word[i], exp_w);
      check({n, "_sb_bits"}, cap_bits[i], 24);
      last_word[i] = cap_word[i];
      last_bits[i] = cap_bits[i];
      done_cnt[i]++;
      done_iv[i] = cycle - last_done_cyc[i];
      last_done_cyc[i] = cycle;
    end
    if (cs_n_v[i]) begin
      cap_bits[i] = 0;
      cap_word[i] = '0;
      if (low_run[i] > 0) last_low[i] = low_run[i];
      low_run[i] = 0;
      high_run[i]++;
    end else begin
      if (high_run[i] > 0) last_high[i] = high_run[i];
      high_run[i] = 0;
      low_run[i]++;
    end
  endtask

  // model advances on the edge, DUT compared just after it
  always @(posedge clk) begin
    cycle++;
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      compare(i);
      monitor(i);
    end
  end

  // driver helpers, all bounded
  task automatic wait_cs_low(input int i, input int limit);
    for (int n = 0; n < limit && cs_n_v[i]; n++) @(negedge clk);
    if (cs_n_v[i]) fail_timeout({inst_name(i), "_wait_cs_low"});
  endtask

  task automatic wait_done(input int i, input int limit);
    int n0;
    n0 = done_cnt[i];
    for (int n = 0; n < limit && done_cnt[i] == n0; n++) @(negedge clk);
    if (done_cnt[i] == n0) fail_timeout({inst_name(i), "_wait_done"});
  endtask

  task automatic wait_bits(input int i, input int nbits, input int limit);
    for (int n = 0; n < limit && cap_bits[i] < nbits; n++) @(negedge clk);
    if (cap_bits[i] < nbits) fail_timeout({inst_name(i), "_wait_bits"});
  endtask

  task automatic scen_a();
    int c0, n_done, lows;
    din[0] = 16'hA5C3;
    repeat (3) @(negedge clk);
    check("a_rst_cs_n", cs_n_v[0], 1'b1);
    check("a_rst_sclk", sclk_v[0], 1'b0);
    check("a_rst_mosi", mosi_v[0], 1'b0);
    check("a_rst_busy", busy_v[0], 1'b0);
    check("a_rst_done", done_v[0], 1'b0);
    check("a_rst_overrun", ovr_v[0], 1'b0);
    check("a_rst_state", st_v[0], ST_IDLE);
    rst_v[0] = 1'b0;
    en_v[0]  = 1'b1;
    c0 = cycle;
    wait_cs_low(0, 300);
    check("a_first_tick_latency", cycle - c0, 120);
    wait_done(0, 200);
    check("a_frame1_word", last_word[0], 24'h30A5C3);
    check("a_frame1_rises", last_bits[0], 24);
    check("a_frame1_cs_low_len", last_low[0], 100);
    check("a_frame1_overrun", ovr_v[0], 1'b0);
    // data_in changes mid-frame do not reach the frame in flight
    wait_cs_low(0, 200);
    repeat (10) @(negedge clk);
    din[0] = 16'h0000;
    wait_done(0, 200);
    check("a_frame2_word", last_word[0], 24'h30A5C3);
    check("a_frame2_interval", done_iv[0], 120);
    wait_done(0, 300);
    check("a_frame3_word", last_word[0], 24'h300000);
    // reset at the 12th rising sclk edge aborts the frame
    din[0] = 16'h1234;
    wait_cs_low(0, 200);
    wait_bits(0, 12, 200);
    n_done = done_cnt[0];
    rst_v[0] = 1'b1;
    #1;
    check("a_abort_cs_n", cs_n_v[0], 1'b1);
    check("a_abort_sclk", sclk_v[0], 1'b0);
    check("a_abort_busy", busy_v[0], 1'b0);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0;
    din[0]   = 16'h7E81;
    c0 = cycle;
    wait_cs_low(0, 300);
    check("a_post_reset_latency", cycle - c0, 120);
    wait_done(0, 200);
    check("a_post_reset_done_count", done_cnt[0], n_done + 1);
    check("a_post_reset_word", last_word[0], 24'h307E81);
    // enable dropped mid-frame: frame completes, nothing further starts
    wait_cs_low(0, 200);
    repeat (20) @(negedge clk);
    en_v[0] = 1'b0;
    wait_done(0, 200);
    check("a_disable_word", last_word[0], 24'h307E81);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (!cs_n_v[0]) lows++;
    end
    check("a_disabled_cs_quiet", lows, 0);
    check("a_disabled_overrun", ovr_v[0], 1'b0);
  endtask

  task automatic scen_b();
    din[1] = 16'h5A3C;
    repeat (3) @(negedge clk);
    rst_v[1] = 1'b0;
    en_v[1]  = 1'b1;
    wait_cs_low(1, 200);
    check("b_overrun_before_second_tick", ovr_v[1], 1'b0);
    wait_done(1, 200);
    check("b_overrun_after_second_tick", ovr_v[1], 1'b1);
    check("b_frame1_word", last_word[1], 24'h305A3C);
    din[1] = 16'hFFFF;
    wait_done(1, 300);
    check("b_frame2_word", last_word[1], 24'h30FFFF);
    check("b_frame2_interval", done_iv[1], 120);
    wait_done(1, 300);
    check("b_frame3_interval", done_iv[1], 120);
    en_v[1] = 1'b0;
    @(negedge clk);
    check("b_overrun_cleared", ovr_v[1], 1'b0);
  endtask

  task automatic scen_c();
    din[2] = 16'h8001;
    repeat (3) @(negedge clk);
    rst_v[2] = 1'b0;
    en_v[2]  = 1'b1;
    wait_done(2, 200);
    wait_done(2, 200);
    wait_done(2, 200);
    check("c_cs_high_gap", last_high[2], 1);
    check("c_cs_low_len", last_low[2], 50);
    check("c_done_interval", done_iv[2], 51);
    check("c_word", last_word[2], 24'h308001);
    check("c_overrun", ovr_v[2], 1'b0);
    en_v[2] = 1'b0;
  endtask

  // run scenarios and report
  initial begin
    fork
      scen_a();
      scen_b();
      scen_c();
    join
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 2: system clocks per SCLK half-period; legal range 1..255.
REQ-002 Parameter SAMPLE_PERIOD, default 1000: system clocks between sample ticks; legal range 2..65535.
REQ-003 Parameter DAC_CMD, default 8'h30: 8-bit command byte prefixed to every frame (write-and-update).
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 enable  in  1  allows new frames to start.
REQ-007 data_in  in  16  sample from the generator multiplexer output; offset-binary.
REQ-008 sclk  out  1  SPI clock; idles low.
REQ-009 mosi  out  1  SPI data, MSB first.
REQ-010 cs_n  out  1  DAC chip select, active-low.
REQ-011 busy  out  1  high while state is not IDLE.
REQ-012 frame_done  out  1  one-clock pulse when a frame completes.
REQ-013 overrun  out  1  sticky; a tick arrived while not IDLE.

Function
REQ-014 The internal sample counter counts 0..SAMPLE_PERIOD-1 while enable=1, asserts tick at SAMPLE_PERIOD-1, then wraps to 0; while enable=0 it is held at 0.
REQ-015 FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP.
REQ-016 IDLE + tick: at that edge, latch the 24-bit frame {DAC_CMD, data_in}, cs_n<=0, mosi<=frame[23], go to CS_SETUP.
REQ-017 CS_SETUP lasts CLK_DIV clocks with sclk=0, then goes to SHIFT.
REQ-018 SHIFT sends 24 bits; each bit is CLK_DIV clocks sclk=0 followed by CLK_DIV clocks sclk=1.
REQ-019 mosi changes only on the edge that drives sclk low; the DAC samples on sclk rising.
REQ-020 After the 24th high phase: sclk<=0, go to CS_HOLD for CLK_DIV clocks with cs_n=0.
REQ-021 On leaving CS_HOLD: cs_n<=1, frame_done=1 for one clock, go to GAP.
REQ-022 GAP lasts CLK_DIV clocks with cs_n=1, then returns to IDLE.
REQ-023 Total frame time is tick edge to IDLE re-entry = 51*CLK_DIV clocks; cs_n is low for exactly 50*CLK_DIV clocks.
REQ-024 data_in changes after the latch edge have no effect on the frame in flight.
REQ-025 A tick in any state other than IDLE is dropped (no queueing) and sets overrun=1.
REQ-026 overrun clears on the clock after enable=0, or on reset.
REQ-027 enable falling mid-frame: the current frame completes normally; no new frame starts.
REQ-028 enable rising: the first tick occurs SAMPLE_PERIOD clocks later.
REQ-029 The bit counter is 5 bits and the half-period counter is 8 bits; no other widths are required.

Reset
REQ-030 rst=1 immediately forces: state IDLE, sclk=0, mosi=0, cs_n=1, busy=0, frame_done=0, overrun=0, all counters and the shift register to 0.
REQ-031 Reset mid-frame aborts the frame without completing it; after release the first tick occurs SAMPLE_PERIOD clocks after enable is seen high.

Structure
REQ-032 The shared package dac_spi_pkg holds the state enum, FRAME_BITS=24, and the default DAC_CMD constant.
REQ-033 The sample counter is a sub-module, tick_gen, a modulo-N counter with enable that produces a one-clock tick.
REQ-034 The FSM, half-period counter, bit counter and shift register live in dac_spi_tx.

Verification
REQ-035 CLK_DIV=2, SAMPLE_PERIOD=120, data_in=16'hA5C3, enable=1 -> 24 sclk rising edges, mosi sampled = 24'h30A5C3, cs_n low for 100 clocks, one frame_done pulse per 120 clocks, overrun=0.
REQ-036 Same setup, data_in toggled to 16'h0000 at clock 10 of the frame -> frame still carries 16'hA5C3; the next frame carries 16'h0000.
REQ-037 CLK_DIV=2, SAMPLE_PERIOD=60 -> overrun=1 on the second tick; every other tick is dropped; the frames that are sent stay intact; enable=0 clears overrun.
REQ-038 rst pulsed at the 12th sclk rising edge -> cs_n=1, sclk=0 in the same cycle; no frame_done; a clean full frame follows the next tick.
REQ-039 enable dropped mid-frame -> the frame finishes with frame_done; no further cs_n activity while enable=0.
REQ-040 CLK_DIV=1, SAMPLE_PERIOD=51 -> back-to-back frames with zero overrun; cs_n high for exactly 1 clock between frames.
